// File: rtl/sprite_compositor.sv
// Composites NUM_SPR sprite layers, a diamond cursor and a shots-remaining HUD over
// the background stream; three-cycle pixel pipeline matched to 1-cycle sprite ROMs.
module sprite_compositor #(
  parameter int          NUM_SPR   = 4,
  parameter int          ADDR_W    = 14,
  parameter int          MAX_SHOTS = 3,
  parameter logic [11:0] KEY_RGB   = 12'h6AF,
  parameter int          HUD_X0    = 68,
  parameter int          HUD_Y0    = 418,
  parameter int          HUD_W     = 9,
  parameter int          HUD_H     = 13,
  parameter int          HUD_PITCH = 17
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  input  logic [NUM_SPR*10-1:0]     spr_x,
  input  logic [NUM_SPR*10-1:0]     spr_y,
  input  logic [NUM_SPR*7-1:0]      spr_w,
  input  logic [NUM_SPR*7-1:0]      spr_h,
  input  logic [NUM_SPR*10-1:0]     spr_clip_y,
  input  logic [NUM_SPR-1:0]        spr_en,
  output logic [NUM_SPR*ADDR_W-1:0] spr_addr,
  input  logic [NUM_SPR*12-1:0]     spr_rgb,
  input  logic [11:0]               bg_rgb,
  input  logic [9:0]                cursor_x,
  input  logic [9:0]                cursor_y,
  input  logic [9:0]                cursor_size,
  input  logic                      fire,
  input  logic                      reload,
  output logic [2:0]                shots_left,
  output logic                      empty,
  output logic [3:0]                Red,
  output logic [3:0]                Green,
  output logic [3:0]                Blue
);

  // Sprite geometry is only sampled during vertical blank so a frame never tears.
  logic [NUM_SPR*10-1:0] sh_x, sh_y, sh_clip;
  logic [NUM_SPR*7-1:0]  sh_w, sh_h;
  logic [NUM_SPR-1:0]    sh_en;

  always_ff @(posedge vga_clk) begin
    if (Reset || DrawY >= 10'd480) begin
      sh_x    <= spr_x;
      sh_y    <= spr_y;
      sh_w    <= spr_w;
      sh_h    <= spr_h;
      sh_clip <= spr_clip_y;
      sh_en   <= spr_en;
    end
  end

  logic [NUM_SPR-1:0]        hit0;
  logic [NUM_SPR*ADDR_W-1:0] addr0;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_layer
    logic [9:0] dx, dy;
    logic [6:0] w, h;
    assign w  = sh_w[i*7 +: 7];
    assign h  = sh_h[i*7 +: 7];
    assign dx = DrawX - sh_x[i*10 +: 10];
    assign dy = DrawY - sh_y[i*10 +: 10];
    assign hit0[i] = sh_en[i] & (dx < {3'b000, w}) & (dy < {3'b000, h})
                   & (DrawY < sh_clip[i*10 +: 10]);
    assign addr0[i*ADDR_W +: ADDR_W] =
      hit0[i] ? (ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(w)) : '0;
  end

  // Diamond cursor: Manhattan distance from the centre within the radius.
  logic [10:0] cdx, cdy, adx, ady;
  logic [11:0] csum;
  logic        cur0;
  assign cdx  = {1'b0, DrawX} - {1'b0, cursor_x};
  assign cdy  = {1'b0, DrawY} - {1'b0, cursor_y};
  assign adx  = cdx[10] ? (~cdx + 11'd1) : cdx;
  assign ady  = cdy[10] ? (~cdy + 11'd1) : cdy;
  assign csum = {1'b0, adx} + {1'b0, ady};
  assign cur0 = csum <= {2'b00, cursor_size};

  logic hud0;
  always_comb begin
    hud0 = 1'b0;
    if (DrawY >= 10'(HUD_Y0) && DrawY < 10'(HUD_Y0 + HUD_H)) begin
      for (int i = 0; i < MAX_SHOTS; i++) begin
        if (3'(i) < shots_left &&
            DrawX >= 10'(HUD_X0 + i*HUD_PITCH) &&
            DrawX <  10'(HUD_X0 + i*HUD_PITCH + HUD_W))
          hud0 = 1'b1;
      end
    end
  end

  logic [NUM_SPR-1:0] hit1, hit2;
  logic               cur1, cur2, hud1, hud2, blank1, blank2;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      spr_addr <= '0;
      hit1     <= '0;
      cur1     <= 1'b0;
      hud1     <= 1'b0;
      blank1   <= 1'b0;
      hit2     <= '0;
      cur2     <= 1'b0;
      hud2     <= 1'b0;
      blank2   <= 1'b0;
    end else begin
      spr_addr <= addr0;
      hit1     <= hit0;
      cur1     <= cur0;
      hud1     <= hud0;
      blank1   <= blank;
      hit2     <= hit1;
      cur2     <= cur1;
      hud2     <= hud1;
      blank2   <= blank1;
    end
  end

  // Later assignments win, so layers are walked from lowest to highest priority.
  logic [11:0] pix;
  always_comb begin
    pix = bg_rgb;
    if (hud2) pix = 12'hAAA;
    for (int i = NUM_SPR-1; i >= 0; i--) begin
      if (hit2[i] && spr_rgb[i*12 +: 12] != KEY_RGB) pix = spr_rgb[i*12 +: 12];
    end
    if (cur2)    pix = 12'hFFF;
    if (!blank2) pix = 12'h000;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      Red   <= 4'h0;
      Green <= 4'h0;
      Blue  <= 4'h0;
    end else begin
      Red   <= pix[11:8];
      Green <= pix[7:4];
      Blue  <= pix[3:0];
    end
  end

  // Reload dominates; a held fire level yields a single rising edge.
  logic fire_d;
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      shots_left <= 3'(MAX_SHOTS);
      fire_d     <= 1'b0;
    end else begin
      fire_d <= fire;
      if (reload)
        shots_left <= 3'(MAX_SHOTS);
      else if (fire && !fire_d && shots_left != 3'd0)
        shots_left <= shots_left - 3'd1;
    end
  end

  assign empty = (shots_left == 3'd0);

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: frame-level pixel model with per-cycle comparison
// plus hand-computed literal checks of addresses, colours and the shot counter.
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int AW = 14;
  localparam int MAXS = 3;
  localparam logic [11:0] KEY = 12'h6AF;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic          Reset, blank, fire, reload, empty;
  logic [9:0]    DrawX, DrawY, cursor_x, cursor_y, cursor_size;
  logic [NS*10-1:0] spr_x, spr_y, spr_clip_y;
  logic [NS*7-1:0]  spr_w, spr_h;
  logic [NS-1:0]    spr_en;
  logic [NS*AW-1:0] spr_addr;
  logic [NS*12-1:0] spr_rgb;
  logic [11:0]   bg_rgb;
  logic [2:0]    shots_left;
  logic [3:0]    Red, Green, Blue;

  sprite_compositor dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_clip_y(spr_clip_y), .spr_en(spr_en), .spr_addr(spr_addr),
    .spr_rgb(spr_rgb), .bg_rgb(bg_rgb), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_size(cursor_size), .fire(fire), .reload(reload),
    .shots_left(shots_left), .empty(empty), .Red(Red), .Green(Green), .Blue(Blue)
  );

  int total = 0, bad = 0, cyc = 0;
  bit chk_on = 0;

  // Requested layer settings, and the bench's own copy of what the frame should use.
  int lx[NS], ly[NS], lw[NS], lh[NS], lclip[NS];
  bit len[NS];
  int mx[NS], my[NS], mw[NS], mh[NS], mclip[NS];
  bit men[NS];
  logic [11:0] rom_col[NS];

  int m_shots, e_shots;
  bit m_fd;
  bit n_reset, n_fire, n_reload;
  logic [11:0]      e_rgb[4];
  logic [NS*AW-1:0] e_addr[4];
  int hx[4], hy[4];

  function automatic logic [11:0] rom_of(int i, logic [AW-1:0] a);
    return rom_col[i] ^ {8'h00, a[3:0]};
  endfunction

  function automatic logic [11:0] bg_of(int x, int y);
    return 12'(x*5 + y*3);
  endfunction

  always @(posedge vga_clk)
    for (int i = 0; i < NS; i++) spr_rgb[i*12 +: 12] <= rom_of(i, spr_addr[i*AW +: AW]);

  function automatic bit layer_hit(int i, int x, int y);
    int dx = (x - mx[i]) & 1023;
    int dy = (y - my[i]) & 1023;
    return men[i] && dx < mw[i] && dy < mh[i] && y < mclip[i];
  endfunction

  function automatic int layer_addr(int i, int x, int y);
    int dx = (x - mx[i]) & 1023;
    int dy = (y - my[i]) & 1023;
    if (!layer_hit(i, x, y)) return 0;
    return (dx + dy*mw[i]) % (1 << AW);
  endfunction

  function automatic logic [11:0] model_pix(int x, int y, bit b, int shots);
    int ax = x - int'(cursor_x);
    int ay = y - int'(cursor_y);
    logic [11:0] c;
    if (!b) return 12'h000;
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    if (ax + ay <= int'(cursor_size)) return 12'hFFF;
    for (int i = 0; i < NS; i++) begin
      if (layer_hit(i, x, y)) begin
        c = rom_of(i, AW'(layer_addr(i, x, y)));
        if (c != KEY) return c;
      end
    end
    for (int i = 0; i < MAXS && i < shots; i++)
      if (y >= 418 && y < 431 && x >= 68 + 17*i && x < 68 + 17*i + 9) return 12'hAAA;
    return bg_of(x, y);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply_layers();
    for (int i = 0; i < NS; i++) begin
      spr_x[i*10 +: 10]      = 10'(lx[i]);
      spr_y[i*10 +: 10]      = 10'(ly[i]);
      spr_w[i*7 +: 7]        = 7'(lw[i]);
      spr_h[i*7 +: 7]        = 7'(lh[i]);
      spr_clip_y[i*10 +: 10] = 10'(lclip[i]);
      spr_en[i]              = len[i];
    end
  endtask

  // One pixel clock: drive inputs, predict the pixel, then advance the bench state.
  task automatic step(input int x, input int y, input bit b);
    @(posedge vga_clk); #1;
    cyc++;
    Reset = n_reset; fire = n_fire; reload = n_reload;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    for (int j = 3; j > 0; j--) begin
      e_rgb[j] = e_rgb[j-1]; e_addr[j] = e_addr[j-1];
      hx[j] = hx[j-1]; hy[j] = hy[j-1];
    end
    hx[0] = x; hy[0] = y;
    bg_rgb = bg_of(hx[2], hy[2]);
    e_shots = m_shots;
    e_rgb[0] = model_pix(x, y, b, m_shots);
    for (int i = 0; i < NS; i++) e_addr[0][i*AW +: AW] = AW'(layer_addr(i, x, y));
    if (n_reset) begin
      e_rgb[0] = '0; e_rgb[1] = '0; e_rgb[2] = '0; e_addr[0] = '0;
      m_shots = MAXS; m_fd = 0;
    end else begin
      if (n_reload) m_shots = MAXS;
      else if (n_fire && !m_fd && m_shots > 0) m_shots--;
      m_fd = n_fire;
    end
    if (n_reset || y >= 480)
      for (int i = 0; i < NS; i++) begin
        mx[i] = lx[i]; my[i] = ly[i]; mw[i] = lw[i]; mh[i] = lh[i];
        mclip[i] = lclip[i]; men[i] = len[i];
      end
    chk_on = 1;
  endtask

  task automatic idle();
    step(0, 0, 0);
  endtask

  task automatic vblank();
    idle(); step(0, 500, 0); idle();
  endtask

  task automatic show(input int x, input int y, input bit b,
                      output logic [11:0] rgb, output logic [AW-1:0] a0);
    step(x, y, b); idle();
    @(negedge vga_clk); a0 = spr_addr[AW-1:0];
    idle(); idle();
    @(negedge vga_clk); rgb = {Red, Green, Blue};
  endtask

  always @(negedge vga_clk) begin
    if (chk_on) begin
      chk("rgb", 64'({Red, Green, Blue}), 64'(e_rgb[3]));
      chk("spr_addr", 64'(spr_addr), 64'(e_addr[1]));
      chk("shots_left", 64'(shots_left), 64'(e_shots));
      chk("empty", 64'(empty), 64'(e_shots == 0));
    end
  end

  task automatic pulse_fire();
    n_fire = 1; step(70, 420, 1); step(87, 420, 1);
    n_fire = 0; step(104, 420, 1); step(70, 420, 1);
  endtask

  logic [11:0]   rgb;
  logic [AW-1:0] a0;

  initial begin
    n_reset = 1; n_fire = 0; n_reload = 0;
    Reset = 1; fire = 0; reload = 0; DrawX = 0; DrawY = 0; blank = 0; bg_rgb = 0;
    cursor_x = 10'd1000; cursor_y = 10'd1000; cursor_size = 10'd0;
    for (int i = 0; i < NS; i++) begin
      lx[i] = 0; ly[i] = 0; lw[i] = 0; lh[i] = 0; lclip[i] = 1023; len[i] = 0;
      e_rgb[i] = '0; e_addr[i] = '0; hx[i] = 0; hy[i] = 0;
    end
    rom_col[0] = 12'h123; rom_col[1] = 12'h456; rom_col[2] = 12'h789; rom_col[3] = 12'hABC;
    lx[0] = 100; ly[0] = 100; lw[0] = 110; lh[0] = 86; len[0] = 1;
    apply_layers();
    m_shots = MAXS; m_fd = 0;

    repeat (3) idle();
    @(negedge vga_clk);
    chk("reset rgb", 64'({Red, Green, Blue}), 64'h0);
    chk("reset shots", 64'(shots_left), 64'd3);
    chk("reset empty", 64'(empty), 64'd0);
    chk("reset addr", 64'(spr_addr), 64'h0);
    n_reset = 0;
    idle(); idle();

    // Single sprite: corners, addresses and the pixel just past the right edge.
    show(100, 100, 1, rgb, a0);
    chk("spr0 addr tl", 64'(a0), 64'd0);
    chk("spr0 rgb tl", 64'(rgb), 64'h123);
    show(209, 185, 1, rgb, a0);
    chk("spr0 addr br", 64'(a0), 64'd9459);
    chk("spr0 rgb br", 64'(rgb), 64'h120);
    show(210, 100, 1, rgb, a0);
    chk("spr0 right bg", 64'(rgb), 64'h546);
    for (int x = 95; x < 216; x += 5) step(x, 120, 1);
    idle(); idle(); idle();

    // Overlap with a keyed top layer.
    lx[1] = 100; ly[1] = 100; lw[1] = 20; lh[1] = 20; len[1] = 1;
    rom_col[0] = KEY;
    apply_layers(); vblank();
    show(100, 100, 1, rgb, a0);
    chk("key falls through", 64'(rgb), 64'h456);
    show(101, 100, 1, rgb, a0);
    chk("layer0 non-key", 64'(rgb), 64'h6AE);
    for (int x = 96; x < 124; x += 3) step(x, 105, 1);
    idle(); idle(); idle();
    rom_col[0] = 12'h123;
    show(100, 100, 1, rgb, a0);
    chk("layer0 wins", 64'(rgb), 64'h123);

    // Vertical clip.
    len[1] = 0; ly[0] = 280; lclip[0] = 300;
    apply_layers(); vblank();
    show(100, 299, 1, rgb, a0);
    chk("clip row 299", 64'(rgb), 64'h129);
    show(100, 300, 1, rgb, a0);
    chk("clip row 300", 64'(rgb), 64'h578);
    chk("clip addr", 64'(a0), 64'd0);
    for (int y = 296; y < 304; y++) step(150, y, 1);
    idle(); idle(); idle();

    // Mid-frame position change must wait for the next vertical blank.
    ly[0] = 190; lclip[0] = 1023;
    apply_layers(); vblank();
    for (int y = 195; y < 206; y++) begin
      if (y == 200) begin lx[0] = 300; apply_layers(); end
      step(100, y, 1); step(300, y, 1);
    end
    idle(); idle(); idle();
    show(100, 250, 1, rgb, a0);
    chk("old x kept", 64'(rgb), 64'h12B);
    show(300, 250, 1, rgb, a0);
    chk("new x not yet", 64'(rgb), 64'h8CA);
    step(100, 479, 1); step(0, 480, 0); idle();
    show(300, 250, 1, rgb, a0);
    chk("new x next frame", 64'(rgb), 64'h12B);
    show(100, 250, 1, rgb, a0);
    chk("old x gone", 64'(rgb), 64'h4E2);

    // Reset in the middle of a line flushes the pipeline.
    for (int i = 0; i < 10; i++) begin
      n_reset = (i == 3);
      step(300 + i, 250, 1);
    end
    n_reset = 0;
    repeat (4) step(320, 260, 1);
    idle(); idle(); idle();

    // Shot counter and HUD.
    pulse_fire();
    chk("shots 2", 64'(shots_left), 64'd2);
    pulse_fire();
    chk("shots 1", 64'(shots_left), 64'd1);
    idle();
    show(70, 420, 1, rgb, a0);
    chk("hud square 0", 64'(rgb), 64'hAAA);
    show(87, 420, 1, rgb, a0);
    chk("hud square 1 off", 64'(rgb), 64'h69F);
    pulse_fire();
    chk("shots 0", 64'(shots_left), 64'd0);
    chk("empty set", 64'(empty), 64'd1);
    pulse_fire();
    chk("shots stay 0", 64'(shots_left), 64'd0);
    idle();
    show(70, 420, 1, rgb, a0);
    chk("hud gone", 64'(rgb), 64'h64A);
    n_reload = 1; step(70, 420, 1);
    n_reload = 0; step(87, 420, 1);
    chk("reload", 64'(shots_left), 64'd3);
    n_fire = 1; n_reload = 1; step(104, 420, 1);
    n_fire = 0; n_reload = 0; step(104, 420, 1);
    chk("reload beats fire", 64'(shots_left), 64'd3);
    n_fire = 1;
    for (int i = 0; i < 100; i++) step(68 + (i % 40), 418 + (i % 14), 1);
    n_fire = 0; step(70, 420, 1);
    chk("held fire once", 64'(shots_left), 64'd2);
    idle(); idle(); idle();

    // Cursor over blanked and active video.
    len[0] = 0; apply_layers(); vblank();
    cursor_x = 10'd320; cursor_y = 10'd240; cursor_size = 10'd5;
    show(320, 240, 0, rgb, a0);
    chk("cursor blanked", 64'(rgb), 64'h000);
    show(323, 242, 1, rgb, a0);
    chk("cursor edge", 64'(rgb), 64'hFFF);
    show(324, 242, 1, rgb, a0);
    chk("cursor outside", 64'(rgb), 64'h92A);
    for (int y = 233; y < 248; y += 2)
      for (int x = 312; x < 329; x += 3) step(x, y, 1);
    idle(); idle(); idle(); idle();

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
